// File: rtl/sram_pattern_writer.sv
// Write-side front end for the DE2-115 IS61WV102416 async SRAM.
// Ports: CLOCK_50, KEY (KEY[0] async active-low reset), host write
//   handshake (wr_valid/wr_ready/wr_addr/wr_data), status (fill_done,
//   busy, words_written) and the SRAM pins (ADDR, DQ, WE_N, OE_N, CE_N,
//   LB_N, UB_N). Auto-fills FILL_WORDS words after reset, then accepts
//   host writes; every write is a timed WE_N-controlled cycle.
module sram_pattern_writer #(
  parameter int FILL_WORDS = 16,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        CLOCK_50,
  input  logic        KEY,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [19:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        fill_done,
  output logic        busy,
  output logic [15:0] words_written,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [2:0] {
    F_SETUP, F_PULSE, F_HOLD, IDLE,
    W_SETUP, W_PULSE, W_HOLD
  } state_t;

  localparam logic [3:0]  S_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0]  P_LAST = 4'(PULSE_CYC - 1);
  localparam logic [3:0]  H_LAST = 4'(HOLD_CYC - 1);
  localparam logic [16:0] F_END  = 17'(FILL_WORDS);

  state_t      state;
  logic [3:0]  phase;
  logic [16:0] fill_addr;
  logic [15:0] dq_out;
  logic        rst_n;

  logic [16:0] fill_next;
  logic [3:0]  pat;

  assign rst_n     = KEY;
  assign fill_next = fill_addr + 17'd1;
  assign pat       = fill_next[3:0];

  assign SRAM_CE_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;

  // OE_N is high exactly when a write cycle owns the bus, so it doubles
  // as the DQ drive enable and the two can never overlap.
  assign SRAM_DQ = SRAM_OE_N ? dq_out : 16'hzzzz;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= F_SETUP;
      phase         <= 4'd0;
      fill_addr     <= 17'd0;
      dq_out        <= 16'h0000;
      SRAM_ADDR     <= 20'd0;
      SRAM_WE_N     <= 1'b1;
      SRAM_OE_N     <= 1'b1;
      wr_ready      <= 1'b0;
      fill_done     <= 1'b0;
      busy          <= 1'b1;
      words_written <= 16'd0;
    end else begin
      phase <= phase + 4'd1;
      unique case (state)
        F_SETUP, W_SETUP: begin
          if (phase == S_LAST) begin
            phase     <= 4'd0;
            SRAM_WE_N <= 1'b0;
            state     <= (state == F_SETUP) ? F_PULSE : W_PULSE;
          end
        end
        F_PULSE, W_PULSE: begin
          if (phase == P_LAST) begin
            phase     <= 4'd0;
            SRAM_WE_N <= 1'b1;
            state     <= (state == F_PULSE) ? F_HOLD : W_HOLD;
          end
        end
        F_HOLD: begin
          if (phase == H_LAST) begin
            phase     <= 4'd0;
            fill_addr <= fill_next;
            if (fill_next == F_END) begin
              state     <= IDLE;
              SRAM_OE_N <= 1'b0;
              wr_ready  <= 1'b1;
              busy      <= 1'b0;
              fill_done <= 1'b1;
            end else begin
              state     <= F_SETUP;
              SRAM_ADDR <= {3'd0, fill_next};
              dq_out    <= {pat, pat, pat, pat};
            end
          end
        end
        W_HOLD: begin
          if (phase == H_LAST) begin
            phase         <= 4'd0;
            state         <= IDLE;
            SRAM_OE_N     <= 1'b0;
            wr_ready      <= 1'b1;
            busy          <= 1'b0;
            words_written <= words_written + 16'd1;
          end
        end
        IDLE: begin
          phase <= 4'd0;
          if (wr_valid) begin
            state     <= W_SETUP;
            SRAM_ADDR <= wr_addr;
            dq_out    <= wr_data;
            SRAM_OE_N <= 1'b1;
            wr_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        default: begin
          phase <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_pattern_writer.sv
// Directed bench for sram_pattern_writer with a behavioural SRAM
// that captures DQ on the rising edge of WE_N.
module tb_sram_pattern_writer;

  logic        clk = 1'b0;
  logic        key;
  logic        wr_valid;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        fill_done;
  logic        busy;
  logic [15:0] words_written;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_lb_n;
  logic        sram_ub_n;

  int compares = 0;
  int fails    = 0;
  int we_low   = 0;
  int we_pulse = 0;

  logic [15:0] mem [0:4095];

  sram_pattern_writer dut (
    .CLOCK_50      (clk),
    .KEY           (key),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .fill_done     (fill_done),
    .busy          (busy),
    .words_written (words_written),
    .SRAM_ADDR     (sram_addr),
    .SRAM_DQ       (sram_dq),
    .SRAM_WE_N     (sram_we_n),
    .SRAM_OE_N     (sram_oe_n),
    .SRAM_CE_N     (sram_ce_n),
    .SRAM_LB_N     (sram_lb_n),
    .SRAM_UB_N     (sram_ub_n)
  );

  always #5 clk = ~clk;

  always @(posedge sram_we_n)
    if (!sram_ce_n) mem[sram_addr[11:0]] = sram_dq;

  always @(negedge clk)
    if (sram_we_n === 1'b0) we_low = we_low + 1;

  always @(negedge sram_we_n)
    we_pulse = we_pulse + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    compares++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill_check(input string tag);
    logic rdy_seen;
    rdy_seen = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i < 64 && wr_ready) rdy_seen = 1'b1;
      if (i == 63) chk({tag, "_done_e63"}, 32'(fill_done), 32'd0);
    end
    chk({tag, "_done_e64"}, 32'(fill_done), 32'd1);
    chk({tag, "_rdy_fill"}, 32'(rdy_seen), 32'd0);
    chk({tag, "_pulses"}, we_pulse, 16);
    chk({tag, "_we_low"}, we_low, 32);
  endtask

  initial begin
    logic [3:0]  n;
    logic [15:0] pw;
    logic        rdy;
    logic        rdy_seen;
    int          k;
    int          e;
    int          acc_edge [3];

    key = 1'b1;
    wr_valid = 1'b0;
    wr_addr = 20'd0;
    wr_data = 16'd0;
    #2 key = 1'b0;
    #1;
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq", 32'(sram_dq), 32'h0000);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_count", 32'(words_written), 32'd0);
    chk("rst_fixed", {29'd0, sram_ce_n, sram_lb_n, sram_ub_n}, 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    key = 1'b1;
    we_low = 0;
    we_pulse = 0;

    // fill, with a stray request on edge 10
    rdy_seen = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (i == 10) begin
        wr_valid = 1'b1;
        wr_addr = 20'h00005;
        wr_data = 16'hDEAD;
      end
      tick();
      if (i == 10) wr_valid = 1'b0;
      if (i < 64 && wr_ready) rdy_seen = 1'b1;
      if (i == 63) chk("fill_done_e63", 32'(fill_done), 32'd0);
    end
    chk("fill_done_e64", 32'(fill_done), 32'd1);
    chk("fill_rdy_seen", 32'(rdy_seen), 32'd0);
    chk("idle_ready", 32'(wr_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_oe_n", 32'(sram_oe_n), 32'd0);
    chk("fill_pulses", we_pulse, 16);
    chk("fill_we_low", we_low, 32);
    chk("fill_count", 32'(words_written), 32'd0);
    for (int i = 0; i < 16; i++) begin
      n = 4'(i);
      pw = {n, n, n, n};
      chk($sformatf("fill_mem%0d", i), 32'(mem[i]), 32'(pw));
    end

    // single host write
    wr_valid = 1'b1;
    wr_addr = 20'h00005;
    wr_data = 16'hBEEF;
    tick();
    wr_valid = 1'b0;
    wr_addr = 20'hABCDE;
    wr_data = 16'h1357;
    chk("w1_acc_ready", 32'(wr_ready), 32'd0);
    chk("w1_acc_oe_n", 32'(sram_oe_n), 32'd1);
    chk("w1_acc_we_n", 32'(sram_we_n), 32'd1);
    chk("w1_acc_addr", 32'(sram_addr), 32'h00005);
    chk("w1_acc_dq", 32'(sram_dq), 32'hBEEF);
    tick();
    chk("w1_n1_we_n", 32'(sram_we_n), 32'd0);
    chk("w1_n1_addr", 32'(sram_addr), 32'h00005);
    chk("w1_n1_dq", 32'(sram_dq), 32'hBEEF);
    tick();
    chk("w1_n2_we_n", 32'(sram_we_n), 32'd0);
    tick();
    chk("w1_n3_we_n", 32'(sram_we_n), 32'd1);
    chk("w1_n3_ready", 32'(wr_ready), 32'd0);
    tick();
    chk("w1_n4_ready", 32'(wr_ready), 32'd1);
    chk("w1_count", 32'(words_written), 32'd1);
    chk("w1_oe_n", 32'(sram_oe_n), 32'd0);
    chk("w1_mem5", 32'(mem[5]), 32'hBEEF);

    // back-to-back writes with wr_valid held
    k = 0;
    e = 0;
    wr_valid = 1'b1;
    wr_addr = 20'h00100;
    wr_data = 16'h0001;
    for (int c = 0; c < 40 && k < 3; c++) begin
      rdy = wr_ready;
      tick();
      e++;
      if (rdy) begin
        acc_edge[k] = e;
        k++;
        wr_addr = 20'h00100 + 20'(k);
        wr_data = 16'(k + 1);
        if (k == 3) wr_valid = 1'b0;
      end
    end
    chk("b2b_accepts", k, 3);
    chk("b2b_gap01", acc_edge[1] - acc_edge[0], 5);
    chk("b2b_gap12", acc_edge[2] - acc_edge[1], 5);
    for (int c = 0; c < 10 && !wr_ready; c++) tick();
    chk("b2b_ready", 32'(wr_ready), 32'd1);
    chk("b2b_mem100", 32'(mem[12'h100]), 32'h0001);
    chk("b2b_mem101", 32'(mem[12'h101]), 32'h0002);
    chk("b2b_mem102", 32'(mem[12'h102]), 32'h0003);
    chk("b2b_count", 32'(words_written), 32'd4);

    // counter wrap
    force dut.words_written = 16'hFFFF;
    #1 release dut.words_written;
    #1;
    chk("wrap_pre", 32'(words_written), 32'hFFFF);
    wr_valid = 1'b1;
    wr_addr = 20'h00007;
    wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    repeat (4) tick();
    chk("wrap_ready", 32'(wr_ready), 32'd1);
    chk("wrap_count", 32'(words_written), 32'h0000);
    chk("wrap_mem7", 32'(mem[7]), 32'h1234);
    chk("wrap_mem5", 32'(mem[5]), 32'hBEEF);
    chk("wrap_mem8", 32'(mem[8]), 32'h8888);

    // reset in the middle of W_PULSE
    wr_valid = 1'b1;
    wr_addr = 20'h00020;
    wr_data = 16'hAAAA;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("abort_pre_we_n", 32'(sram_we_n), 32'd0);
    #2 key = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
    chk("abort_ready", 32'(wr_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_count", 32'(words_written), 32'd0);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    for (int i = 0; i < 16; i++) mem[i] = 16'h5A5A;
    @(negedge clk);
    key = 1'b1;
    we_low = 0;
    we_pulse = 0;
    refill_check("refill");
    chk("refill_count", 32'(words_written), 32'd0);
    chk("refill_mem3", 32'(mem[3]), 32'h3333);
    chk("refill_mem5", 32'(mem[5]), 32'h5555);
    chk("refill_mem15", 32'(mem[15]), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compares, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
